// File: rtl/issue_fetch_req_scheduler_pkg.sv
// Shared sizing constants for the issue-to-fetch request scheduler.
`default_nettype none

package issue_fetch_req_scheduler_pkg;

  localparam int unsigned IFRS_WF_PER_CU    = 40;
  localparam int unsigned IFRS_WF_ID_LENGTH = 6;
  localparam int unsigned IFRS_CNT_WIDTH    = 2;

endpackage

`default_nettype wire

// File: rtl/issue_fetch_req_scheduler_rr_priority_picker.sv
// Rotating-priority find-first: first set bit of req_i at or after base_i, wrapping modulo N.
`default_nettype none

module rr_priority_picker
  import issue_fetch_req_scheduler_pkg::*;
#(
  parameter int unsigned N   = IFRS_WF_PER_CU,
  parameter int unsigned IDW = IFRS_WF_ID_LENGTH
) (
  input  logic [N-1:0]   req_i,
  input  logic [IDW-1:0] base_i,
  output logic           found_o,
  output logic [IDW-1:0] idx_o
);

  logic [IDW:0] pos;

  // N is not a power of two, so the wrap is an explicit subtract rather than truncation.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    pos     = '0;
    for (int i = 0; i < N; i++) begin
      pos = {1'b0, base_i} + (IDW+1)'(i);
      if (pos >= (IDW+1)'(N)) begin
        pos = pos - (IDW+1)'(N);
      end
      if (!found_o && req_i[pos[IDW-1:0]]) begin
        found_o = 1'b1;
        idx_o   = pos[IDW-1:0];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/issue_fetch_req_scheduler.sv
// Serializes per-wavefront instruction-request pulses into a round-robin stream of fetch
// requests, with per-wavefront outstanding counters, flush and a sticky overflow flag.
`default_nettype none

module issue_fetch_req_scheduler
  import issue_fetch_req_scheduler_pkg::*;
#(
  parameter int unsigned WF_PER_CU    = IFRS_WF_PER_CU,
  parameter int unsigned WF_ID_LENGTH = IFRS_WF_ID_LENGTH,
  parameter int unsigned CNT_WIDTH    = IFRS_CNT_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [WF_PER_CU-1:0]    wave_req,
  input  logic [WF_PER_CU-1:0]    wave_flush,
  input  logic                    fetch_ready,
  output logic                    fetch_req_valid,
  output logic [WF_ID_LENGTH-1:0] fetch_req_wfid,
  output logic [WF_PER_CU-1:0]    wave_pending,
  output logic                    req_overflow
);

  localparam logic [CNT_WIDTH-1:0]    CNT_MAX = '1;
  localparam logic [WF_ID_LENGTH-1:0] LAST_WF = WF_ID_LENGTH'(WF_PER_CU - 1);

  logic [CNT_WIDTH-1:0]    cnt_q [WF_PER_CU];
  logic [CNT_WIDTH-1:0]    cnt_d [WF_PER_CU];
  logic [WF_ID_LENGTH-1:0] rr_ptr_q, rr_ptr_d;
  logic [WF_ID_LENGTH-1:0] wfid_q, wfid_d;
  logic                    valid_q, valid_d;
  logic                    ovf_q, ovf_d;

  logic [WF_PER_CU-1:0]    eligible;
  logic                    slot_free;
  logic                    pick_found;
  logic [WF_ID_LENGTH-1:0] pick_idx;
  logic                    load;

  generate
    for (genvar w = 0; w < WF_PER_CU; w++) begin : g_wf
      // A wavefront being flushed this cycle must not be handed to the fetch unit.
      assign eligible[w]     = (cnt_q[w] != '0) && !wave_flush[w];
      assign wave_pending[w] = |cnt_q[w];
    end
  endgenerate

  rr_priority_picker #(
    .N   (WF_PER_CU),
    .IDW (WF_ID_LENGTH)
  ) u_picker (
    .req_i   (eligible),
    .base_i  (rr_ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  assign slot_free = !valid_q || fetch_ready;
  assign load      = slot_free && pick_found;

  always_comb begin
    valid_d  = valid_q;
    wfid_d   = wfid_q;
    rr_ptr_d = rr_ptr_q;
    if (slot_free) begin
      valid_d = pick_found;
      if (pick_found) begin
        wfid_d   = pick_idx;
        rr_ptr_d = (pick_idx == LAST_WF) ? '0 : pick_idx + 1'b1;
      end
    end else if (wave_flush[wfid_q]) begin
      // Withdrawn before transfer; its count was already consumed, so nothing to refund.
      valid_d = 1'b0;
    end
  end

  always_comb begin
    ovf_d = ovf_q;
    for (int w = 0; w < WF_PER_CU; w++) begin
      cnt_d[w] = cnt_q[w];
      if (wave_flush[w]) begin
        cnt_d[w] = '0;
      end else if (wave_req[w] && load && (pick_idx == WF_ID_LENGTH'(w))) begin
        cnt_d[w] = cnt_q[w];
      end else if (wave_req[w]) begin
        if (cnt_q[w] == CNT_MAX) begin
          ovf_d = 1'b1;
        end else begin
          cnt_d[w] = cnt_q[w] + 1'b1;
        end
      end else if (load && (pick_idx == WF_ID_LENGTH'(w))) begin
        cnt_d[w] = cnt_q[w] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int w = 0; w < WF_PER_CU; w++) begin
        cnt_q[w] <= '0;
      end
      rr_ptr_q <= '0;
      wfid_q   <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      rr_ptr_q <= rr_ptr_d;
      wfid_q   <= wfid_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
    end
  end

  assign fetch_req_valid = valid_q;
  assign fetch_req_wfid  = wfid_q;
  assign req_overflow    = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_issue_fetch_req_scheduler.sv
// Directed scenarios plus randomized traffic, checked against a counting reference model.
`default_nettype none

module tb_issue_fetch_req_scheduler;

  localparam int N    = 40;
  localparam int IDW  = 6;
  localparam int MAXC = 3;

  logic           clk;
  logic           rst;
  logic [N-1:0]   wave_req;
  logic [N-1:0]   wave_flush;
  logic           fetch_ready;
  logic           fetch_req_valid;
  logic [IDW-1:0] fetch_req_wfid;
  logic [N-1:0]   wave_pending;
  logic           req_overflow;

  int total;
  int bad;

  int m_cnt [N];
  int m_rr;
  bit m_valid;
  int m_wfid;
  bit m_ovf;

  issue_fetch_req_scheduler dut (
    .clk             (clk),
    .rst             (rst),
    .wave_req        (wave_req),
    .wave_flush      (wave_flush),
    .fetch_ready     (fetch_ready),
    .fetch_req_valid (fetch_req_valid),
    .fetch_req_wfid  (fetch_req_wfid),
    .wave_pending    (wave_pending),
    .req_overflow    (req_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] bitw(input int w);
    logic [N-1:0] one;
    one = 1;
    return one << w;
  endfunction

  function automatic void model_reset();
    for (int w = 0; w < N; w++) m_cnt[w] = 0;
    m_rr    = 0;
    m_valid = 0;
    m_wfid  = 0;
    m_ovf   = 0;
  endfunction

  function automatic logic [N-1:0] model_pending();
    logic [N-1:0] p;
    p = '0;
    for (int w = 0; w < N; w++) if (m_cnt[w] > 0) p |= bitw(w);
    return p;
  endfunction

  // One clock edge of the intended behaviour: pick, then net count change per wavefront.
  function automatic void model_step(input logic [N-1:0] rq, input logic [N-1:0] fl,
                                     input logic rdy);
    bit sf;
    int found;
    int c;
    sf    = !m_valid || rdy;
    found = -1;
    if (sf) begin
      for (int i = 0; i < N; i++) begin
        int w;
        w = (m_rr + i) % N;
        if (found < 0 && m_cnt[w] > 0 && !fl[w]) found = w;
      end
    end
    for (int w = 0; w < N; w++) begin
      if (fl[w]) begin
        m_cnt[w] = 0;
      end else begin
        c = m_cnt[w] + (rq[w] ? 1 : 0) - ((found == w) ? 1 : 0);
        if (c > MAXC) begin
          c     = MAXC;
          m_ovf = 1;
        end
        m_cnt[w] = c;
      end
    end
    if (sf) begin
      m_valid = (found >= 0);
      if (found >= 0) begin
        m_wfid = found;
        m_rr   = (found + 1) % N;
      end
    end else if (fl[m_wfid]) begin
      m_valid = 0;
    end
  endfunction

  task automatic check_outputs();
    chk_eq("valid", 64'(fetch_req_valid), 64'(m_valid));
    if (m_valid) chk_eq("wfid", 64'(fetch_req_wfid), 64'(m_wfid));
    chk_eq("pending", 64'(wave_pending), 64'(model_pending()));
    chk_eq("overflow", 64'(req_overflow), 64'(m_ovf));
  endtask

  task automatic cycle(input logic [N-1:0] rq, input logic [N-1:0] fl, input logic rdy);
    wave_req    = rq;
    wave_flush  = fl;
    fetch_ready = rdy;
    model_step(rq, fl, rdy);
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    logic [63:0]  r1, r2, r3;
    logic [N-1:0] rq, fl, focus;
    total       = 0;
    bad         = 0;
    rst         = 1'b0;
    wave_req    = '0;
    wave_flush  = '0;
    fetch_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk_eq("rst_valid", 64'(fetch_req_valid), 64'd0);
    chk_eq("rst_wfid", 64'(fetch_req_wfid), 64'd0);
    chk_eq("rst_pending", 64'(wave_pending), 64'd0);
    chk_eq("rst_overflow", 64'(req_overflow), 64'd0);
    rst = 1'b1;

    // Reset mid-stream: wf 3 held with two more outstanding.
    cycle(bitw(3), '0, 1'b0);
    cycle(bitw(3), '0, 1'b0);
    cycle(bitw(3), '0, 1'b0);
    chk_eq("mid_valid_before", 64'(fetch_req_valid), 64'd1);
    chk_eq("mid_pend3_before", 64'(wave_pending[3]), 64'd1);
    #1 rst = 1'b0;
    #1;
    model_reset();
    chk_eq("mid_rst_valid", 64'(fetch_req_valid), 64'd0);
    chk_eq("mid_rst_pending", 64'(wave_pending), 64'd0);
    chk_eq("mid_rst_overflow", 64'(req_overflow), 64'd0);
    #1 rst = 1'b1;
    repeat (3) begin
      cycle('0, '0, 1'b1);
      chk_eq("post_rst_no_grant", 64'(fetch_req_valid), 64'd0);
    end

    // Single request latency.
    cycle(bitw(5), '0, 1'b1);
    chk_eq("single_pend_n1", 64'(wave_pending[5]), 64'd1);
    chk_eq("single_valid_n1", 64'(fetch_req_valid), 64'd0);
    cycle('0, '0, 1'b1);
    chk_eq("single_valid_n2", 64'(fetch_req_valid), 64'd1);
    chk_eq("single_wfid_n2", 64'(fetch_req_wfid), 64'd5);
    chk_eq("single_pend_n2", 64'(wave_pending[5]), 64'd0);
    cycle('0, '0, 1'b1);
    chk_eq("single_valid_n3", 64'(fetch_req_valid), 64'd0);

    // Round robin with wrap: move rr_ptr to 8 by granting wf 7 first.
    cycle(bitw(7), '0, 1'b1);
    cycle('0, '0, 1'b1);
    chk_eq("rr_setup_wfid", 64'(fetch_req_wfid), 64'd7);
    cycle(bitw(0) | bitw(7) | bitw(39), '0, 1'b0);
    cycle('0, '0, 1'b1);
    chk_eq("rr_grant1", 64'(fetch_req_wfid), 64'd39);
    cycle('0, '0, 1'b1);
    chk_eq("rr_grant2", 64'(fetch_req_wfid), 64'd0);
    cycle('0, '0, 1'b1);
    chk_eq("rr_grant3", 64'(fetch_req_wfid), 64'd7);
    cycle('0, '0, 1'b1);
    chk_eq("rr_idle", 64'(fetch_req_valid), 64'd0);

    // Backpressure.
    cycle(bitw(12) | bitw(20), '0, 1'b1);
    cycle('0, '0, 1'b0);
    repeat (4) begin
      cycle('0, '0, 1'b0);
      chk_eq("bp_wfid_stable", 64'(fetch_req_wfid), 64'd12);
      chk_eq("bp_cnt20_kept", 64'(wave_pending[20]), 64'd1);
    end
    cycle('0, '0, 1'b1);
    chk_eq("bp_next_wfid", 64'(fetch_req_wfid), 64'd20);
    cycle('0, '0, 1'b1);

    // Flush of the held wavefront, then flush with a coincident request.
    cycle(bitw(12), '0, 1'b0);
    cycle(bitw(12), '0, 1'b0);
    chk_eq("fl_held", 64'(fetch_req_wfid), 64'd12);
    cycle('0, bitw(12), 1'b0);
    chk_eq("fl_valid", 64'(fetch_req_valid), 64'd0);
    chk_eq("fl_pend12", 64'(wave_pending[12]), 64'd0);
    cycle(bitw(12), bitw(12), 1'b0);
    chk_eq("fl_coinc_pend12", 64'(wave_pending[12]), 64'd0);
    cycle('0, '0, 1'b1);

    // Saturation: hold wf 30 so four pulses to wf 2 all land in its counter.
    chk_eq("sat_ovf_pre", 64'(req_overflow), 64'd0);
    cycle(bitw(30), '0, 1'b0);
    repeat (4) cycle(bitw(2), '0, 1'b0);
    chk_eq("sat_ovf", 64'(req_overflow), 64'd1);
    chk_eq("sat_held30", 64'(fetch_req_wfid), 64'd30);
    repeat (3) begin
      cycle('0, '0, 1'b1);
      chk_eq("sat_grant_valid", 64'(fetch_req_valid), 64'd1);
      chk_eq("sat_grant_wf2", 64'(fetch_req_wfid), 64'd2);
    end
    cycle('0, '0, 1'b1);
    chk_eq("sat_done", 64'(fetch_req_valid), 64'd0);

    // Randomized traffic, alternating between a narrow hot set and the full range.
    focus = bitw(1) | bitw(2) | bitw(3) | bitw(38) | bitw(39);
    for (int k = 0; k < 1500; k++) begin
      r1 = {$urandom(), $urandom()};
      r2 = {$urandom(), $urandom()};
      r3 = {$urandom(), $urandom()};
      rq = r1[N-1:0] & r2[N-1:0] & r3[N-1:0];
      if ((k / 300) % 2 == 1) begin
        rq = r1[N-1:0] & focus;
      end
      fl = '0;
      if ($urandom_range(0, 15) == 0) fl = bitw(int'($urandom_range(0, N - 1)));
      if ($urandom_range(0, 31) == 0 && m_valid) fl = fl | bitw(m_wfid);
      cycle(rq, fl, 1'($urandom_range(0, 3) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
